ram_n: RTL and testbench

Parametrised successor to the team's fixed 8x16 RAM. Width and depth are configurable. Reads are combinational and writes happen on the clock edge, as before. New behaviour: a synchronous active-low reset starts a hardware clear sequencer that zeroes every word, one word per cycle, and a `busy` flag covers that sweep. Out-of-range addresses are handled for non-power-of-two depths. Sits under the CPU data memory hierarchy as the generic building block replacing the fixed RAM8/RAM64 instances.

---
 rtl/ram_n.sv | 80 ++++++++
 tb/tb_ram_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_n.sv
// Parameterised single-port RAM with combinational read and a post-reset clear sweep.
// Define RAM_PARITY_EN to store a per-word even-parity bit with error injection and checking.
module ram_n #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
`ifdef RAM_PARITY_EN
  input  logic              inject,
  output logic              parity_err,
`endif
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_ptr, w_clr_ptr_nxt;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_in_range;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt   = S_IDLE;
        else                                 w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Non-power-of-two depths leave a hole in the address space; it neither reads nor writes.
  assign w_in_range = (32'(address) < DEPTH);
  assign w_idx      = w_in_range ? address : '0;
  assign busy       = (r_state == S_CLEAR);
  assign w_wr       = (r_state == S_IDLE) && load && w_in_range;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == S_CLEAR) r_mem[r_clr_ptr] <= '0;
      else if (w_wr)          r_mem[w_idx]     <= in;
    end
  end

  assign out = (busy || !w_in_range) ? '0 : r_mem[w_idx];

`ifdef RAM_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == S_CLEAR) r_par[r_clr_ptr] <= 1'b0;
      else if (w_wr)          r_par[w_idx]     <= (^in) ^ inject;
    end
  end

  assign parity_err = !busy && w_in_range && ((^r_mem[w_idx]) != r_par[w_idx]);
`endif

endmodule

// File: tb/tb_ram_n.sv
// Randomised self-checking bench for ram_n: default 8x16 instance plus a 5x8 non-power-of-two instance.
// Expected values come from a word-array model with a clear-cycles-remaining counter.
module tb_ram_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_in, a_out;
  logic [2:0]  a_addr;
  logic        a_load, a_busy, a_inj, a_perr;
  logic [7:0]  b_in, b_out;
  logic [2:0]  b_addr;
  logic        b_load, b_busy, b_inj, b_perr;

  ram_n u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .load(a_load), .address(a_addr),
`ifdef RAM_PARITY_EN
    .inject(a_inj), .parity_err(a_perr),
`endif
    .out(a_out), .busy(a_busy)
  );

  ram_n #(.WIDTH(8), .DEPTH(5), .ADDR_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .load(b_load), .address(b_addr),
`ifdef RAM_PARITY_EN
    .inject(b_inj), .parity_err(b_perr),
`endif
    .out(b_out), .busy(b_busy)
  );

  // reference model
  logic [15:0] ma [8];
  bit          pa [8];
  int          la;
  logic [7:0]  mb [5];
  bit          pb [5];
  int          lb;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (!rst_n) begin
      la = 8; lb = 5;
      for (int i = 0; i < 8; i++) begin ma[i] = '0; pa[i] = 1'b0; end
      for (int i = 0; i < 5; i++) begin mb[i] = '0; pb[i] = 1'b0; end
    end else begin
      if (la > 0) la--;
      else if (a_load) begin ma[a_addr] = a_in; pa[a_addr] = (^a_in) ^ a_inj; end
      if (lb > 0) lb--;
      else if (b_load && b_addr < 5) begin mb[b_addr] = b_in; pb[b_addr] = (^b_in) ^ b_inj; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] ea;
    logic [7:0]  eb;
    bit          bok;
    #1;
    bok = (lb == 0) && (b_addr < 5);
    ea  = (la > 0) ? 16'h0 : ma[a_addr];
    eb  = bok ? mb[b_addr] : 8'h0;
    chk({tag, " a_busy"}, 32'(a_busy), 32'(la > 0));
    chk({tag, " a_out"},  32'(a_out),  32'(ea));
    chk({tag, " b_busy"}, 32'(b_busy), 32'(lb > 0));
    chk({tag, " b_out"},  32'(b_out),  32'(eb));
`ifdef RAM_PARITY_EN
    chk({tag, " a_perr"}, 32'(a_perr), 32'((la == 0) && ((^ma[a_addr]) != pa[a_addr])));
    chk({tag, " b_perr"}, 32'(b_perr), 32'(bok && ((^mb[b_addr]) != pb[b_addr])));
`endif
  endtask

  initial begin
    rst_n = 1'b0; a_load = 0; a_addr = 0; a_in = 0; a_inj = 0;
    b_load = 0; b_addr = 0; b_in = 0; b_inj = 0;
    la = 0; lb = 0;

    // 1: reset, exact busy length, cleared contents
    tick(); tick();
    chk("rst a_busy", 32'(a_busy), 32'd1);
    chk("rst b_busy", 32'(b_busy), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("clr a_busy", 32'(a_busy), 32'd1);
      chk("clr b_busy", 32'(b_busy), 32'(i < 5));
      chk("clr a_out",  32'(a_out),  32'd0);
      tick();
    end
    chk("clr a_done", 32'(a_busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      a_addr = 3'(k); #1;
      chk("clr zero", 32'(a_out), 32'd0);
    end

    // 2: fill and read back
    a_load = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_addr = 3'(k); a_in = 16'(16'h1000 * k); tick();
    end
    a_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_addr = 3'(k); #1;
      chk("fill rd", 32'(a_out), 32'(16'h1000 * k));
    end

    // 3: writes during clear are dropped
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a_load = 1'b1; a_addr = 3'd3; a_in = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("busywr busy", 32'(a_busy), 32'd1);
      chk("busywr out",  32'(a_out),  32'd0);
      tick();
    end
    a_load = 1'b0; #1;
    chk("busywr after", 32'(a_out), 32'd0);

    // 4: reset mid-sweep restarts the full sweep
    a_load = 1'b1; a_in = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin a_addr = 3'(k); tick(); end
    a_load = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk("restart busy", 32'(a_busy), 32'd1); tick();
    end
    chk("restart done", 32'(a_busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      a_addr = 3'(k); #1;
      chk("restart zero", 32'(a_out), 32'd0);
    end

    // 5: non-power-of-two depth, out-of-range address
    b_load = 1'b1;
    b_addr = 3'd6; b_in = 8'hAA; tick();
    b_addr = 3'd4; b_in = 8'h55; tick();
    b_load = 1'b0;
    b_addr = 3'd6; #1; chk("oor rd6", 32'(b_out), 32'h00);
    b_addr = 3'd4; #1; chk("oor rd4", 32'(b_out), 32'h55);
    for (int k = 0; k < 4; k++) begin
      b_addr = 3'(k); #1; chk("oor alias", 32'(b_out), 32'h00);
    end

`ifdef RAM_PARITY_EN
    // 6: parity injection, then clear
    a_load = 1'b1;
    a_addr = 3'd2; a_in = 16'h0001; a_inj = 1'b1; tick();
    a_addr = 3'd1; a_in = 16'h0003; a_inj = 1'b0; tick();
    a_load = 1'b0;
    a_addr = 3'd2; #1; chk("par inj", 32'(a_perr), 32'd1);
    a_addr = 3'd1; #1; chk("par ok",  32'(a_perr), 32'd0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    for (int k = 0; k < 8; k++) begin
      a_addr = 3'(k); #1; chk("par clr", 32'(a_perr), 32'd0);
    end
`endif

    // randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      a_load = $urandom_range(0, 1) == 1; a_addr = 3'($urandom_range(0, 7));
      a_in   = 16'($urandom);             a_inj  = ($urandom_range(0, 3) == 0);
      b_load = $urandom_range(0, 1) == 1; b_addr = 3'($urandom_range(0, 7));
      b_in   = 8'($urandom);              b_inj  = ($urandom_range(0, 3) == 0);
      #1; check_all("rnd pre");
      tick();
      check_all("rnd post");
      a_addr = 3'($urandom_range(0, 7)); b_addr = 3'($urandom_range(0, 7));
      check_all("rnd rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
